// File: rtl/ldiv_result_fifo_if.sv
// Handshake bundle between the divider-side producer/consumer and the result FIFO.
// The master modport is the environment (upstream, divider, consumer); slave is the FIFO.
interface ldiv_result_fifo_if #(
  parameter int NUMERATOR_WIDTH = 10,
  parameter int QUOTIENT_WIDTH  = 10,
  parameter int DEPTH           = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                       issue;
  logic                       issue_ok;
  logic                       valid_in;
  logic [QUOTIENT_WIDTH-1:0]  quotient_in;
  logic [NUMERATOR_WIDTH-1:0] remainder_in;
  logic                       valid_out;
  logic                       ready_in;
  logic [QUOTIENT_WIDTH-1:0]  quotient_out;
  logic [NUMERATOR_WIDTH-1:0] remainder_out;
  logic [CW-1:0]              count;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output issue, valid_in, quotient_in, remainder_in, ready_in,
    input  issue_ok, valid_out, quotient_out, remainder_out, count, overflow, underflow
  );

  modport slave (
    input  issue, valid_in, quotient_in, remainder_in, ready_in,
    output issue_ok, valid_out, quotient_out, remainder_out, count, overflow, underflow
  );
endinterface

// File: rtl/ldiv_result_fifo.sv
// Credit-managed first-word-fall-through result buffer for a divider pipeline that
// cannot be stalled: upstream may only issue while buffered plus in-flight results fit.
module ldiv_result_fifo #(
  parameter int NUMERATOR_WIDTH = 10,
  parameter int QUOTIENT_WIDTH  = 10,
  parameter int DEPTH           = 16
) (
  input  logic               clk,
  input  logic               reset,
  ldiv_result_fifo_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam int EW = QUOTIENT_WIDTH + NUMERATOR_WIDTH;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
  localparam logic [SW-1:0] DEPTH_SUM = SW'(DEPTH);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("ldiv_result_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [EW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          wr_s;
  logic          issue_ok_s;
  logic [SW-1:0] credit_sum_s;

  // Handshake decode: pop, write qualification and credit availability.
  always_comb begin
    empty_s      = (count_q == CNT_ZERO);
    full_s       = (count_q == DEPTH_C);
    pop_s        = (!empty_s) && bus.ready_in;
    // A full buffer can still accept a result if the head leaves on the same edge.
    wr_s         = bus.valid_in && ((!full_s) || pop_s);
    credit_sum_s = {1'b0, count_q} + {1'b0, inflight_q};
    issue_ok_s   = (credit_sum_s < DEPTH_SUM);
  end

  // Occupancy and pointer next-state.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (wr_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // In-flight operation tracking, saturating at both ends.
  always_comb begin
    inflight_d = inflight_q;
    case ({bus.issue, bus.valid_in})
      2'b10: begin
        if (inflight_q == DEPTH_C) begin
          inflight_d = inflight_q;
        end else begin
          inflight_d = inflight_q + CNT_ONE;
        end
      end
      2'b01: begin
        if (inflight_q == CNT_ZERO) begin
          inflight_d = inflight_q;
        end else begin
          inflight_d = inflight_q - CNT_ONE;
        end
      end
      default: inflight_d = inflight_q;
    endcase
  end

  // Sticky protocol error flags.
  always_comb begin
    overflow_d  = overflow_q
                | (bus.issue && (!issue_ok_s))
                | (bus.valid_in && full_s && (!pop_s));
    underflow_d = underflow_q | (bus.valid_in && (inflight_q == CNT_ZERO));
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      count_q     <= CNT_ZERO;
      inflight_q  <= CNT_ZERO;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Result storage; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    if ((!reset) && wr_s) begin
      mem_q[wr_ptr_q] <= {bus.quotient_in, bus.remainder_in};
    end
  end

  assign bus.issue_ok  = issue_ok_s;
  assign bus.valid_out = !empty_s;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign {bus.quotient_out, bus.remainder_out} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ldiv_result_fifo.sv
// Bench for ldiv_result_fifo: directed table, corner sequences and randomized traffic
// compared against a queue-based model of the credit/FIFO rules.
module tb_ldiv_result_fifo;
  localparam int NW    = 10;
  localparam int QW    = 10;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ldiv_result_fifo_if #(.NUMERATOR_WIDTH(NW), .QUOTIENT_WIDTH(QW), .DEPTH(DEPTH)) bus ();

  ldiv_result_fifo #(.NUMERATOR_WIDTH(NW), .QUOTIENT_WIDTH(QW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int mq[$];
  int mr[$];
  int m_infl = 0;
  bit m_ov = 1'b0;
  bit m_un = 1'b0;

  typedef struct {
    bit rst; bit iss; bit vin; int q; int r; bit rdy;
    int e_count; bit e_vo; bit e_ok; bit e_ov; bit e_un; int e_q;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("count", int'(bus.count), mq.size());
    chk("valid_out", int'(bus.valid_out), int'(mq.size() > 0));
    chk("issue_ok", int'(bus.issue_ok), int'((mq.size() + m_infl) < DEPTH));
    chk("overflow", int'(bus.overflow), int'(m_ov));
    chk("underflow", int'(bus.underflow), int'(m_un));
    if (mq.size() > 0) begin
      chk("quotient_out", int'(bus.quotient_out), mq[0]);
      chk("remainder_out", int'(bus.remainder_out), mr[0]);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the spec rules, check after the edge.
  task automatic tick(input bit rst, input bit iss, input bit vin,
                      input int q, input int r, input bit rdy);
    int  sz;
    bit  pop;
    bit  wr;
    reset            = rst;
    bus.issue        = iss;
    bus.valid_in     = vin;
    bus.quotient_in  = QW'(q);
    bus.remainder_in = NW'(r);
    bus.ready_in     = rdy;
    sz = mq.size();
    if (rst) begin
      mq.delete();
      mr.delete();
      m_infl = 0;
      m_ov   = 1'b0;
      m_un   = 1'b0;
    end else begin
      pop = (sz > 0) && rdy;
      wr  = vin && ((sz < DEPTH) || pop);
      if (iss && !((sz + m_infl) < DEPTH)) m_ov = 1'b1;
      if (vin && (sz == DEPTH) && !pop) m_ov = 1'b1;
      if (vin && (m_infl == 0)) m_un = 1'b1;
      if (iss && !vin) m_infl = (m_infl < DEPTH) ? m_infl + 1 : DEPTH;
      else if (vin && !iss && (m_infl > 0)) m_infl = m_infl - 1;
      if (pop) begin
        void'(mq.pop_front());
        void'(mr.pop_front());
      end
      if (wr) begin
        mq.push_back(q % (1 << QW));
        mr.push_back(r % (1 << NW));
      end
    end
    @(posedge clk);
    #1;
    compare_model();
  endtask

  initial begin
    int issued;
    int delivered;
    int got[$];
    bit iss;
    bit vin;
    bit rdy;

    reset = 1'b1;
    bus.issue = 1'b0; bus.valid_in = 1'b0; bus.ready_in = 1'b0;
    bus.quotient_in = '0; bus.remainder_in = '0;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 5, 2, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 5};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 7, 3, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b1, 7};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0};

    for (int i = 0; i < 7; i++) begin
      tick(tbl[i].rst, tbl[i].iss, tbl[i].vin, tbl[i].q, tbl[i].r, tbl[i].rdy);
      chk("tbl_count", int'(bus.count), tbl[i].e_count);
      chk("tbl_valid_out", int'(bus.valid_out), int'(tbl[i].e_vo));
      chk("tbl_issue_ok", int'(bus.issue_ok), int'(tbl[i].e_ok));
      chk("tbl_overflow", int'(bus.overflow), int'(tbl[i].e_ov));
      chk("tbl_underflow", int'(bus.underflow), int'(tbl[i].e_un));
      if (tbl[i].e_vo) chk("tbl_quotient", int'(bus.quotient_out), tbl[i].e_q);
    end

    // Single operation with an 11-cycle divider latency.
    tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 5, 2, 1'b1);
    chk("single_valid", int'(bus.valid_out), 1);
    chk("single_q", int'(bus.quotient_out), 5);
    chk("single_r", int'(bus.remainder_out), 2);
    tick(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    chk("single_count", int'(bus.count), 0);
    chk("single_flags", int'({bus.overflow, bus.underflow}), 0);

    // Credit exhaustion with a stalled consumer.
    tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    issued = 0;
    for (int c = 0; c < 40; c++) begin
      if (!bus.issue_ok) break;
      tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      issued++;
    end
    chk("credits_granted", issued, DEPTH);
    chk("credit_block", int'(bus.issue_ok), 0);
    for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b0, 1'b1, i, 100 + i, 1'b0);
    chk("full_count", int'(bus.count), DEPTH);
    chk("full_overflow", int'(bus.overflow), 0);
    chk("full_underflow", int'(bus.underflow), 0);

    // Push and pop together while full.
    tick(1'b0, 1'b0, 1'b1, 500, 501, 1'b1);
    chk("pushpop_count", int'(bus.count), DEPTH);
    chk("pushpop_head", int'(bus.quotient_out), 1);
    chk("pushpop_overflow", int'(bus.overflow), 0);

    // Credit violation is sticky until reset.
    tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("violation_overflow", int'(bus.overflow), 1);
    repeat (20) tick(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    chk("overflow_sticky", int'(bus.overflow), 1);
    tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("overflow_reset", int'(bus.overflow), 0);

    // Spurious result after reset.
    tick(1'b0, 1'b0, 1'b1, 9, 4, 1'b0);
    chk("spurious_underflow", int'(bus.underflow), 1);
    chk("spurious_count", int'(bus.count), 1);

    // Ordered stream of 40 results across pointer wrap with random ready.
    tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    issued = 0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      if (got.size() >= 40) break;
      iss = bus.issue_ok && (issued < 40) && ($urandom_range(0, 3) != 0);
      vin = ((issued - delivered) > 0) && ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 1) == 1);
      if (bus.valid_out && rdy) got.push_back(int'(bus.quotient_out));
      tick(1'b0, iss, vin, delivered, 3 * delivered, rdy);
      if (iss) issued++;
      if (vin) delivered++;
    end
    chk("stream_len", got.size(), 40);
    for (int i = 0; i < got.size(); i++) chk("stream_order", got[i], i);
    chk("stream_flags", int'({bus.overflow, bus.underflow}), 0);

    // Unconstrained random traffic, including protocol violations and resets.
    tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int c = 0; c < 500; c++) begin
      tick(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 1023)),
           int'($urandom_range(0, 1023)),
           ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
